// File: rtl/add16_share_arb_if.sv
// Request/result bundle shared by the requesters, the arbiter and the result consumer.
// master : requester side plus result consumer (drives operands and res_ready).
// slave  : arbiter side (drives req_ready, result fields and approx_cnt).
//
// Signals:
//   req_valid/req_ready  per-requester handshake, NREQ bits each
//   req_a/req_b          packed operands, requester i at [16i+15:16i]
//   req_exact            per-request exact-add select
//   res_valid/res_ready  result handshake
//   res_sum              17-bit sum, carry out in bit 16
//   res_id               index of the originating requester
//   approx_cnt           saturating count of approximate additions issued
interface add16_share_arb_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*16-1:0] req_a;
   logic [NREQ*16-1:0] req_b;
   logic [NREQ-1:0]    req_exact;
   logic               res_valid;
   logic               res_ready;
   logic [16:0]        res_sum;
   logic [IDW-1:0]     res_id;
   logic [15:0]        approx_cnt;

   modport master (
      output req_valid, req_a, req_b, req_exact, res_ready,
      input  req_ready, res_valid, res_sum, res_id, approx_cnt
   );

   modport slave (
      input  req_valid, req_a, req_b, req_exact, res_ready,
      output req_ready, res_valid, res_sum, res_id, approx_cnt
   );
endinterface

// File: rtl/add16_share_arb.sv
// Round-robin arbiter feeding one shared approximate 16-bit adder into a one-entry output register.
// Latency: operands accepted at a clk edge are on res_sum/res_id with res_valid=1 right after that edge.
// Backpressure: a full register with res_ready=0 holds its result and grants nobody; a drain and a new grant can share a cycle.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset; clears the register, pointer and counter, and masks req_ready
//   bus    add16_share_arb_if.slave (requests, result, approx_cnt)
// Parameters: NREQ requesters (2..8), IDW id width (at least clog2(NREQ)).
// Build option: define ADD16_EXACT_PATH_EN to add an exact 17-bit adder selected per request by req_exact.
module add16_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   add16_share_arb_if.slave bus
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q,   ptr_d;
   logic [16:0]    sum_q,   sum_d;
   logic [IDW-1:0] id_q,    id_d;
   logic [15:0]    cnt_q,   cnt_d;

   // ------------------------------------------------------------------
   // Round-robin search: first valid requester at or above ptr, wrapping.
   // ------------------------------------------------------------------
   logic           found;
   logic [IDW-1:0] win;
   logic [IDW:0]   idx;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         // One extra bit so ptr+k never overflows before the wrap.
         idx = {1'b0, ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ)) begin
            idx = idx - (IDW+1)'(NREQ);
         end
         if (!found && bus.req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            win   = idx[IDW-1:0];
         end
      end
   end

   // rst_n gates the grant so no requester sees ready while reset is held,
   // and the first acceptance can only happen at an edge after release.
   logic grant;
   assign grant = rst_n && found && ((state_q == ST_EMPTY) || bus.res_ready);

   assign bus.req_ready = grant ? (NREQ'(1) << win) : '0;

   // ------------------------------------------------------------------
   // Operand mux for the winner.
   // ------------------------------------------------------------------
   logic [15:0] a_sel;
   logic [15:0] b_sel;
   logic        exact_sel;

   always_comb begin
      a_sel     = '0;
      b_sel     = '0;
      exact_sel = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            a_sel     = bus.req_a[16*i +: 16];
            b_sel     = bus.req_b[16*i +: 16];
            exact_sel = bus.req_exact[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Shared approximate adder (add16u, 8-LUT variant).
   // Upper nine bits are a true add of the high bytes plus B[7] as carry-in;
   // the low byte is built from operand bits and copies of upper sum bits.
   // ------------------------------------------------------------------
   logic [8:0]  approx_hi;
   logic [16:0] sum_approx;

   assign approx_hi  = {1'b0, a_sel[15:8]} + {1'b0, b_sel[15:8]} + {8'b0, b_sel[7]};
   assign sum_approx = {approx_hi,                 // O16..O8
                        a_sel[7],                  // O7
                        a_sel[12] & b_sel[12],     // O6
                        b_sel[5],                  // O5
                        approx_hi[2],              // O4 = O10
                        approx_hi[3],              // O3 = O11
                        a_sel[8] ^ b_sel[8],       // O2
                        approx_hi[1],              // O1 = O9
                        a_sel[7]};                 // O0

   // Low operand bits the approximate adder never looks at.
   logic lsb_unused;
   assign lsb_unused = ^{a_sel[6:0], b_sel[6], b_sel[4:0]};

   // ------------------------------------------------------------------
   // Path select.
   // ------------------------------------------------------------------
   logic        use_exact;
   logic [16:0] sum_sel;

`ifdef ADD16_EXACT_PATH_EN
   logic [16:0] sum_exact;
   assign sum_exact = {1'b0, a_sel} + {1'b0, b_sel};
   assign use_exact = exact_sel;
   assign sum_sel   = use_exact ? sum_exact : sum_approx;
`else
   // Without the exact path every request is approximate and req_exact is ignored.
   logic exact_unused;
   assign exact_unused = exact_sel;
   assign use_exact    = 1'b0;
   assign sum_sel      = sum_approx;
`endif

   // ------------------------------------------------------------------
   // Output register FSM and bookkeeping, next-state logic.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_EMPTY: begin
            if (grant) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // A drain with a simultaneous grant reloads and stays full.
            if (bus.res_ready && !grant) begin
               state_d = ST_EMPTY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase

      if (grant) begin
         sum_d = sum_sel;
         id_d  = win;
         ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
         if (!use_exact && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         sum_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.res_valid  = (state_q == ST_FULL);
   assign bus.res_sum    = sum_q;
   assign bus.res_id     = id_q;
   assign bus.approx_cnt = cnt_q;

endmodule

// File: doc/add16_share_arb.md
ADD16_SHARE_ARB -- requirements
Module: add16_share_arb

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 The module SHALL have parameter IDW, default 2, requester-id width, at least clog2(NREQ).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port req_valid, input, NREQ bits, per-requester operand valid.
REQ-006 The module SHALL have port req_ready, output, NREQ bits, per-requester operand accepted.
REQ-007 The module SHALL have port req_a, input, NREQ*16 bits, operand A, requester i at [16i+15:16i].
REQ-008 The module SHALL have port req_b, input, NREQ*16 bits, operand B, packed the same way as req_a.
REQ-009 The module SHALL have port req_exact, input, NREQ bits, per-request exact-add select.
REQ-010 The module SHALL have port res_valid, output, 1 bit, result valid.
REQ-011 The module SHALL have port res_ready, input, 1 bit, consumer accepts result.
REQ-012 The module SHALL have port res_sum, output, 17 bits, sum.
REQ-013 The module SHALL have port res_id, output, IDW bits, index of the originating requester.
REQ-014 The module SHALL have port approx_cnt, output, 16 bits, saturating count of approximate additions issued.

Function
REQ-015 The module SHALL contain one shared combinational approximate 16-bit adder (ApproxFPGAs add16u, 8 LUT variant).
- Upper part: O[16:8] = A[15:8] + B[15:8] + B[7] (9 bits).
- Lower byte: O0=A7, O1=O9, O2=A8^B8, O3=O11, O4=O10, O5=B5, O6=A12&B12, O7=A7.
REQ-016 Handshake: a transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both 1 at a clk edge; res transfers SHALL occur when res_valid and res_ready are both 1.
REQ-017 At most one req_ready bit SHALL be 1 in any cycle.
REQ-018 req_ready[g] SHALL be 1 only when both hold: g is the round-robin winner among the valid requesters, and the output register is EMPTY or is being drained this cycle (res_ready=1).
REQ-019 Round-robin order: the search SHALL start at pointer ptr and continue upward with wrap modulo NREQ.
- After an accepted grant to g, ptr SHALL become (g+1) mod NREQ.
- Without a grant, ptr SHALL be held.
REQ-020 The output register SHALL be a two-state FSM, EMPTY and FULL.
- EMPTY to FULL on a grant.
- FULL to EMPTY on a drain with no new grant.
- FULL stays FULL on a simultaneous drain and grant; the register reloads that cycle, giving back-to-back throughput of one result per cycle.
REQ-021 Latency: the operands accepted at edge k SHALL appear on res_sum, res_id and res_valid=1 immediately after edge k.
- These outputs SHALL be held stable while res_valid=1 and res_ready=0.
REQ-022 A requester SHALL see req_ready=0 while its request is not granted, with no timeout; a deasserted req_valid SHALL simply drop that requester from arbitration.
REQ-023 approx_cnt SHALL increment on each accepted grant that uses the approximate path, and SHALL saturate at 0xFFFF.
REQ-024 res_sum width rule: the carry out SHALL be res_sum[16], with no truncation.

Reset
REQ-025 While rst_n=0 the following SHALL hold immediately, without waiting for clk:
- FSM=EMPTY, res_valid=0, res_sum=0, res_id=0, ptr=0, approx_cnt=0, req_ready=0.
REQ-026 A reset asserted while the FSM is FULL SHALL discard the held result; that result SHALL NOT be replayed after reset.
REQ-027 The first grant after reset release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Configuration
REQ-028 With macro ADD16_EXACT_PATH_EN defined, the module SHALL contain an exact 17-bit adder.
- Requests with req_exact=1 SHALL get res_sum=A+B.
- Those requests SHALL NOT increment approx_cnt.
REQ-029 Without ADD16_EXACT_PATH_EN, req_exact SHALL be ignored and every request SHALL use the approximate adder and count in approx_cnt.

Verification
REQ-030 The bench SHALL cover: requester 0 with A=0x0100, B=0x0100, exact=0 -> one cycle later res_sum=0x00202, res_id=0, approx_cnt=1.
REQ-031 The bench SHALL cover: the macro defined, A=0x0100, B=0x0100, exact=1 -> res_sum=0x00200, approx_cnt unchanged; the macro undefined -> res_sum=0x00202.
REQ-032 The bench SHALL cover: NREQ=4, all four req_valid held high, res_ready=1 -> grant order 0,1,2,3,0 on five consecutive cycles, one result per cycle.
REQ-033 The bench SHALL cover: res_ready=0 for 3 cycles with a result held -> res_sum and res_id stable, all req_ready=0; on res_ready=1 the next grant is accepted in the same cycle.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-cycle while FULL -> res_valid=0 immediately and ptr=0; after release the lowest valid index is granted first.
REQ-035 The bench SHALL cover: approx_cnt preloaded by 65536 approximate grants, then a further 10 grants -> approx_cnt stays 0xFFFF.
